// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// State encoding, default widths and the alignment mask.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;
  localparam int ALIGN_MASK = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HALTED
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// Write-back record register: data, reg, regWrite, halt, valid.
// Ports: clk, rst_n, ld + next record in; registered record out.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] nxtData,
  input  logic [REG_W-1:0]  nxtReg,
  input  logic              nxtRegWrite,
  input  logic              nxtHalt,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [REG_W-1:0]  dst,
  output logic              regWrite,
  output logic              halt
);

  // valid pulses for the single cycle after a load;
  // the record fields hold until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data     <= '0;
      dst      <= '0;
      regWrite <= 1'b0;
      halt     <= 1'b0;
    end else begin
      valid <= ld;
      if (ld) begin
        data     <= nxtData;
        dst      <= nxtReg;
        regWrite <= nxtRegWrite;
        halt     <= nxtHalt;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: handshaked multi-cycle data memory access.
// Ports: ex_* from ALU stage, stall upstream, mem_* bus, wb_* record, err.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_aluRes,
  input  logic [DATA_W-1:0] ex_memAddr,
  input  logic [DATA_W-1:0] ex_wrData,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_regWrite,
  input  logic [REG_W-1:0]  ex_wrReg,
  input  logic              ex_halt,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_regWrite,
  output logic              wb_halt,
  output logic              err
);

  state_t            state;
  logic [DATA_W-1:0] aluLat;
  logic [REG_W-1:0]  regLat;
  logic              rwLat;
  logic              isLoad;

  logic              isMem;
  logic              misal;
  logic              passIdle;
  logic              misIdle;
  logic              goMem;
  logic              complete;

  logic              wbLd;
  logic [DATA_W-1:0] wbDIn;
  logic [REG_W-1:0]  wbRIn;
  logic              wbRwIn;
  logic              wbHIn;

  assign stall = (state == REQ) || (state == WAIT);

  assign isMem = ex_memRead || ex_memWrite;
  assign misal =
    (ex_memAddr & DATA_W'(ALIGN_MASK)) != '0;

  assign passIdle = (state == IDLE) && ex_valid
                 && !isMem;
  assign misIdle  = (state == IDLE) && ex_valid
                 && isMem && misal;
  assign goMem    = (state == IDLE) && ex_valid
                 && isMem && !misal;

  // Zero-wait completes straight out of REQ.
  assign complete =
    ((state == REQ) && !mem_stall && mem_done)
    || ((state == WAIT) && mem_done);

  always_comb begin
    wbLd   = 1'b0;
    wbDIn  = ex_aluRes;
    wbRIn  = ex_wrReg;
    wbRwIn = ex_regWrite;
    wbHIn  = 1'b0;
    unique case (1'b1)
      passIdle: begin
        wbLd  = 1'b1;
        wbHIn = ex_halt;
      end
      misIdle: begin
        wbLd   = 1'b1;
        wbRwIn = 1'b0;
      end
      complete: begin
        wbLd   = 1'b1;
        wbDIn  = isLoad ? mem_rdata : aluLat;
        wbRIn  = regLat;
        wbRwIn = rwLat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      aluLat    <= '0;
      regLat    <= '0;
      rwLat     <= 1'b0;
      isLoad    <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (passIdle && ex_halt) begin
            state <= HALTED;
          end
          if (misIdle) begin
            err <= 1'b1;
          end
          if (goMem) begin
            mem_rd    <= ex_memRead;
            mem_wr    <= ex_memWrite;
            mem_addr  <= ex_memAddr;
            mem_wdata <= ex_wrData;
            aluLat    <= ex_aluRes;
            regLat    <= ex_wrReg;
            rwLat     <= ex_regWrite;
            isLoad    <= ex_memRead;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!mem_stall) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= mem_done ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state <= IDLE;
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (wbLd),
    .nxtData    (wbDIn),
    .nxtReg     (wbRIn),
    .nxtRegWrite(wbRwIn),
    .nxtHalt    (wbHIn),
    .valid      (wb_valid),
    .data       (wb_data),
    .dst        (wb_reg),
    .regWrite   (wb_regWrite),
    .halt       (wb_halt)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus
// hand sequences for stalls, reset mid-access and HALT.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_aluRes = '0;
  logic [15:0] ex_memAddr = '0;
  logic [15:0] ex_wrData = '0;
  logic        ex_memRead = 1'b0;
  logic        ex_memWrite = 1'b0;
  logic        ex_regWrite = 1'b0;
  logic [2:0]  ex_wrReg = '0;
  logic        ex_halt = 1'b0;
  logic        stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall = 1'b0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_regWrite;
  logic        wb_halt;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_aluRes  (ex_aluRes),
    .ex_memAddr (ex_memAddr),
    .ex_wrData  (ex_wrData),
    .ex_memRead (ex_memRead),
    .ex_memWrite(ex_memWrite),
    .ex_regWrite(ex_regWrite),
    .ex_wrReg   (ex_wrReg),
    .ex_halt    (ex_halt),
    .stall      (stall),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_reg     (wb_reg),
    .wb_regWrite(wb_regWrite),
    .wb_halt    (wb_halt),
    .err        (err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        rw;
    logic        halt;
    logic [15:0] alu;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [2:0]  dst;
    logic [15:0] expData;
    logic        expRw;
    logic        expErr;
    logic        chkData;
  } vec_t;

  vec_t vecs[6];
  vec_t vHalt;
  vec_t vLd2;

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic rw,
    input logic [15:0] alu, input logic [15:0] addr,
    input logic [15:0] wdata, input logic [15:0] rdata,
    input logic [2:0] dst, input logic [15:0] expData,
    input logic expRw, input logic expErr,
    input logic chkData);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.halt = 1'b0;
    v.alu = alu; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.dst = dst; v.expData = expData;
    v.expRw = expRw; v.expErr = expErr;
    v.chkData = chkData;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_aluRes   = v.alu;
    ex_memAddr  = v.addr;
    ex_wrData   = v.wdata;
    ex_memRead  = v.rd;
    ex_memWrite = v.wr;
    ex_regWrite = v.rw;
    ex_wrReg    = v.dst;
    ex_halt     = v.halt;
  endtask

  // One instruction with a zero-wait memory responder.
  task automatic run(input vec_t v, input string t);
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    if ((v.rd || v.wr) && !v.addr[0]) begin
      chk({t, "_reqStall"}, 32'(stall), 1);
      chk({t, "_rd"}, 32'(mem_rd), 32'(v.rd));
      chk({t, "_wr"}, 32'(mem_wr), 32'(v.wr));
      chk({t, "_addr"}, 32'(mem_addr), 32'(v.addr));
      if (v.wr)
        chk({t, "_wdata"}, 32'(mem_wdata), 32'(v.wdata));
      chk({t, "_earlyWb"}, 32'(wb_valid), 0);
      mem_done  = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_done = 1'b0;
    end else begin
      chk({t, "_strobes"}, 32'(mem_rd | mem_wr), 0);
    end
    chk({t, "_valid"}, 32'(wb_valid), 1);
    if (v.chkData) begin
      chk({t, "_data"}, 32'(wb_data), 32'(v.expData));
      chk({t, "_reg"}, 32'(wb_reg), 32'(v.dst));
    end
    chk({t, "_rw"}, 32'(wb_regWrite), 32'(v.expRw));
    chk({t, "_halt"}, 32'(wb_halt), 32'(v.halt));
    chk({t, "_err"}, 32'(err), 32'(v.expErr));
    chk({t, "_stall"}, 32'(stall), 0);
    @(negedge clk);
    chk({t, "_pulse"}, 32'(wb_valid), 0);
  endtask

  initial begin
    vecs[0] = mk(0, 0, 1, 16'h1234, 16'h0000, 16'h0000,
                 16'h0000, 3'd3, 16'h1234, 1, 0, 1);
    vecs[1] = mk(1, 0, 1, 16'h5555, 16'h0040, 16'h0000,
                 16'hBEEF, 3'd5, 16'hBEEF, 1, 0, 1);
    vecs[2] = mk(0, 1, 0, 16'h0022, 16'h0020, 16'h7777,
                 16'hDEAD, 3'd2, 16'h0022, 0, 0, 1);
    vecs[3] = mk(0, 1, 1, 16'h0010, 16'h0010, 16'h00AA,
                 16'h0000, 3'd4, 16'h0010, 1, 0, 1);
    vecs[4] = mk(1, 0, 1, 16'h0099, 16'h0013, 16'h0000,
                 16'h0000, 3'd6, 16'h0000, 0, 1, 0);
    vecs[5] = mk(0, 0, 1, 16'hFFFF, 16'h0000, 16'h0000,
                 16'h0000, 3'd7, 16'hFFFF, 1, 1, 1);
    vLd2 = mk(1, 0, 1, 16'h0000, 16'h0100, 16'h0000,
              16'h4321, 3'd2, 16'h4321, 1, 0, 1);
    vHalt = mk(0, 0, 0, 16'h00FF, 16'h0000, 16'h0000,
               16'h0000, 3'd0, 16'h00FF, 0, 0, 1);
    vHalt.halt = 1'b1;

    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_wb", 32'({wb_valid, wb_regWrite, wb_halt}), 0);
    chk("rst_wbData", 32'(wb_data), 0);
    chk("rst_wbReg", 32'(wb_reg), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run(vecs[i], $sformatf("v%0d", i));

    // LD with two mem_stall cycles then one WAIT cycle.
    @(negedge clk);
    drive(vecs[1]);
    ex_wrReg = 3'd1;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid  = 1'b0;
    mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ldS_rd%0d", c), 32'(mem_rd), 1);
      chk($sformatf("ldS_addr%0d", c), 32'(mem_addr),
          32'h0040);
      chk($sformatf("ldS_stall%0d", c), 32'(stall), 1);
      if (c == 2) mem_stall = 1'b0;
      @(negedge clk);
    end
    chk("ldS_waitRd", 32'(mem_rd), 0);
    chk("ldS_waitStall", 32'(stall), 1);
    chk("ldS_waitWb", 32'(wb_valid), 0);
    mem_done  = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    chk("ldS_valid", 32'(wb_valid), 1);
    chk("ldS_data", 32'(wb_data), 32'hBEEF);
    chk("ldS_reg", 32'(wb_reg), 1);
    chk("ldS_stallLow", 32'(stall), 0);
    @(negedge clk);
    chk("ldS_pulse", 32'(wb_valid), 0);
    chk("ldS_hold", 32'(wb_data), 32'hBEEF);

    // Reset while waiting on memory.
    drive(vecs[1]);
    ex_memAddr = 16'h0080;
    ex_valid   = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rw_req", 32'(mem_rd), 1);
    @(negedge clk);
    chk("rw_waitStall", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_stall", 32'(stall), 0);
    chk("rw_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rw_addr", 32'(mem_addr), 0);
    chk("rw_wbData", 32'(wb_data), 0);
    chk("rw_wb", 32'({wb_valid, wb_regWrite, wb_halt}), 0);
    chk("rw_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(vLd2, "ld2");

    // HALT, then further instructions are ignored.
    run(vHalt, "halt");
    drive(vecs[0]);
    ex_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) drive(vecs[1]);
      mem_done = (c == 4);
      @(negedge clk);
      chk($sformatf("h_wb%0d", c), 32'(wb_valid), 0);
      chk($sformatf("h_strb%0d", c),
          32'({mem_rd, mem_wr}), 0);
      chk($sformatf("h_stall%0d", c), 32'(stall), 0);
      chk($sformatf("h_halt%0d", c), 32'(wb_halt), 1);
    end
    ex_valid = 1'b0;
    mem_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
